// File: rtl/rv64_pkg.sv
// Shared RV64 integer-datapath constants and helpers.
package rv64_pkg;
    localparam int unsigned XLEN       = 64;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction
endpackage

// File: rtl/alu_wb_regfile_if.sv
// ALU result / write-back / read-port bundle between execute and operand fetch.
interface alu_wb_regfile_if;
    import rv64_pkg::*;

    logic [XLEN-1:0]       alu_output;
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  word_op;
    logic                  flush;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [63:0]           instret;

    modport master (
        output alu_output, alu_valid, rd_addr, word_op, flush, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_valid, wb_rd, instret
    );

    modport slave (
        input  alu_output, alu_valid, rd_addr, word_op, flush, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_valid, wb_rd, instret
    );
endinterface

// File: rtl/rv64_regfile.sv
// 31 x XLEN flop array, one write port, two async read ports; x0 reads zero.
module rv64_regfile
    import rv64_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [XLEN-1:0]       i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr1,
    input  logic [REG_ADDR_W-1:0] i_raddr2,
    output logic [XLEN-1:0]       o_rdata1,
    output logic [XLEN-1:0]       o_rdata2
);
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && i_waddr != REG_ZERO) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == REG_ZERO) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == REG_ZERO) ? '0 : r_regs[i_raddr2];
endmodule

// File: rtl/alu_wb_regfile.sv
// Write-back stage: one-entry WB register, commit into the regfile, bypassed reads, instret.
module alu_wb_regfile
    import rv64_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_wb_regfile_if.slave   bus
);
    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [XLEN-1:0]       r_wb_data;
    logic [63:0]           r_instret;

    logic                  w_commit;
    logic [XLEN-1:0]       w_arr_rdata1;
    logic [XLEN-1:0]       w_arr_rdata2;

    assign w_commit = r_wb_valid && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_instret  <= '0;
        end else begin
            if (bus.alu_valid && !bus.flush) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= bus.rd_addr;
                r_wb_data  <= bus.word_op ? sext32(bus.alu_output) : bus.alu_output;
            end else begin
                r_wb_valid <= 1'b0;
            end
            // Commits to x0 still retire an instruction.
            if (w_commit) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    rv64_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_commit),
        .i_waddr  (r_wb_rd),
        .i_wdata  (r_wb_data),
        .i_raddr1 (bus.rs1_addr),
        .i_raddr2 (bus.rs2_addr),
        .o_rdata1 (w_arr_rdata1),
        .o_rdata2 (w_arr_rdata2)
    );

    // Bypass ignores flush: reads are combinational and flush acts only at the edge.
    always_comb begin
        bus.rs1_data = w_arr_rdata1;
        if (bus.rs1_addr == REG_ZERO) begin
            bus.rs1_data = '0;
        end else if (r_wb_valid && bus.rs1_addr == r_wb_rd) begin
            bus.rs1_data = r_wb_data;
        end
    end

    always_comb begin
        bus.rs2_data = w_arr_rdata2;
        if (bus.rs2_addr == REG_ZERO) begin
            bus.rs2_data = '0;
        end else if (r_wb_valid && bus.rs2_addr == r_wb_rd) begin
            bus.rs2_data = r_wb_data;
        end
    end

    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.instret  = r_instret;
endmodule

// File: tb/tb_alu_wb_regfile.sv
// Directed testbench for alu_wb_regfile: capture, bypass, commit, word ops, x0, flush, reset, wrap.
module tb_alu_wb_regfile;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    logic [63:0] exp_instret;

    alu_wb_regfile_if bus ();

    alu_wb_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.alu_valid  = 1'b0;
        bus.alu_output = '0;
        bus.rd_addr    = '0;
        bus.word_op    = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [63:0] val, input logic wop);
        bus.alu_valid  = 1'b1;
        bus.alu_output = val;
        bus.rd_addr    = rd;
        bus.word_op    = wop;
        bus.flush      = 1'b0;
    endtask

    task automatic chk_rs1(input string name, input logic [4:0] a, input logic [63:0] exp);
        bus.rs1_addr = a;
        #1;
        n_total++;
        if (bus.rs1_data !== exp)
            $display("FAIL %s: rs1_data(x%0d)=%h expected %h", name, a, bus.rs1_data, exp);
        else
            n_pass++;
    endtask

    task automatic chk_rs2(input string name, input logic [4:0] a, input logic [63:0] exp);
        bus.rs2_addr = a;
        #1;
        n_total++;
        if (bus.rs2_data !== exp)
            $display("FAIL %s: rs2_data(x%0d)=%h expected %h", name, a, bus.rs2_data, exp);
        else
            n_pass++;
    endtask

    task automatic chk_status(input string name, input logic exp_v, input logic [63:0] exp_ir);
        n_total++;
        if (bus.wb_valid !== exp_v)
            $display("FAIL %s wb_valid: got %b expected %b", name, bus.wb_valid, exp_v);
        else
            n_pass++;
        n_total++;
        if (bus.instret !== exp_ir)
            $display("FAIL %s instret: got %0d expected %0d", name, bus.instret, exp_ir);
        else
            n_pass++;
    endtask

    task automatic test_single();
        @(negedge clk);
        put(5'd5, 64'h1234, 1'b0);
        @(negedge clk);
        idle_inputs();
        chk_rs1("single_bypass", 5'd5, 64'h1234);
        chk_status("single_pending", 1'b1, exp_instret);
        n_total++;
        if (bus.wb_rd !== 5'd5) $display("FAIL single_wb_rd: got %0d expected 5", bus.wb_rd);
        else n_pass++;
        exp_instret++;
        @(negedge clk);
        chk_rs1("single_array", 5'd5, 64'h1234);
        chk_rs2("single_array_p2", 5'd5, 64'h1234);
        chk_status("single_committed", 1'b0, exp_instret);
    endtask

    task automatic test_word_op();
        @(negedge clk);
        put(5'd7, 64'h0000_0000_8000_0001, 1'b1);
        @(negedge clk);
        put(5'd8, 64'h0000_0001_8000_0001, 1'b0);
        chk_rs1("word_bypass", 5'd7, 64'hFFFF_FFFF_8000_0001);
        exp_instret++;
        @(negedge clk);
        put(5'd11, 64'hFFFF_FFFF_7FFF_FFFF, 1'b1);
        chk_rs1("word_array", 5'd7, 64'hFFFF_FFFF_8000_0001);
        chk_rs2("dword_bypass", 5'd8, 64'h0000_0001_8000_0001);
        exp_instret++;
        @(negedge clk);
        idle_inputs();
        chk_rs1("word_pos_bypass", 5'd11, 64'h0000_0000_7FFF_FFFF);
        exp_instret++;
        @(negedge clk);
        chk_rs1("dword_array", 5'd8, 64'h0000_0001_8000_0001);
        chk_rs2("word_pos_array", 5'd11, 64'h0000_0000_7FFF_FFFF);
        chk_status("word_done", 1'b0, exp_instret);
    endtask

    task automatic test_x0();
        @(negedge clk);
        put(5'd0, 64'hDEAD, 1'b0);
        @(negedge clk);
        idle_inputs();
        chk_rs1("x0_no_bypass", 5'd0, 64'h0);
        chk_status("x0_pending", 1'b1, exp_instret);
        exp_instret++;
        @(negedge clk);
        chk_rs2("x0_after_commit", 5'd0, 64'h0);
        chk_status("x0_retired", 1'b0, exp_instret);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        put(5'd3, 64'hA, 1'b0);
        @(negedge clk);
        put(5'd3, 64'hB, 1'b0);
        chk_rs1("b2b_first_bypass", 5'd3, 64'hA);
        exp_instret++;
        @(negedge clk);
        idle_inputs();
        chk_rs1("b2b_second_bypass", 5'd3, 64'hB);
        n_total++;
        if (dut.u_regfile.r_regs[3] !== 64'hA)
            $display("FAIL b2b_array_old: got %h expected %h", dut.u_regfile.r_regs[3], 64'hA);
        else
            n_pass++;
        exp_instret++;
        @(negedge clk);
        chk_rs1("b2b_final", 5'd3, 64'hB);
        chk_status("b2b_done", 1'b0, exp_instret);
    endtask

    task automatic test_flush();
        @(negedge clk);
        put(5'd9, 64'h55, 1'b0);
        @(negedge clk);
        put(5'd10, 64'h77, 1'b0);
        bus.flush = 1'b1;
        chk_rs1("flush_bypass_live", 5'd9, 64'h55);
        @(negedge clk);
        idle_inputs();
        chk_rs1("flush_x9", 5'd9, 64'h0);
        chk_rs2("flush_x10", 5'd10, 64'h0);
        chk_status("flush_state", 1'b0, exp_instret);
        @(negedge clk);
        chk_rs2("flush_x10_later", 5'd10, 64'h0);
        chk_status("flush_later", 1'b0, exp_instret);
    endtask

    task automatic test_reset();
        @(negedge clk);
        put(5'd12, 64'h99, 1'b0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_status("reset_async", 1'b0, 64'd0);
        exp_instret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            chk_rs1("reset_read", i[4:0], 64'h0);
        end
        chk_rs2("reset_x5", 5'd5, 64'h0);
        chk_status("reset_after", 1'b0, 64'd0);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        put(5'd1, 64'h1, 1'b0);
        @(negedge clk);
        idle_inputs();
        chk_status("wrap_before", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk_status("wrap_after", 1'b0, 64'd0);
        chk_rs1("wrap_x1", 5'd1, 64'h1);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        exp_instret = '0;
        idle_inputs();
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_status("initial_reset", 1'b0, 64'd0);
        test_single();
        test_word_op();
        test_x0();
        test_back_to_back();
        test_flush();
        test_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
